// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the APB master arbiter and its round-robin picker.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_t;

  localparam int NUM_MST_DEF        = 4;
  localparam int TIMEOUT_CYCLES_DEF = 256;

  // Timeout counter width: wide enough to hold the limit, kept within 8..16 bits.
  function automatic int tmo_cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    if (w < 8) w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker: searches upward from the slot after last_i
// and returns the first requester as one-hot and as an index.
module apb_rr_picker #(
  parameter int NUM_MST = 4
) (
  input  logic [NUM_MST-1:0]         req_i,
  input  logic [$clog2(NUM_MST)-1:0] last_i,
  output logic [NUM_MST-1:0]         grant_o,
  output logic [$clog2(NUM_MST)-1:0] idx_o,
  output logic                       any_o
);

  localparam int IDX_W = $clog2(NUM_MST);

  int   cand;
  logic found;

  // First requester after last_i, wrapping; last_i itself has lowest priority.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    any_o   = |req_i;
    for (int k = 1; k <= NUM_MST; k++) begin
      cand = (int'(last_i) + k) % NUM_MST;
      if (!found && req_i[IDX_W'(cand)]) begin
        found                   = 1'b1;
        idx_o                   = IDX_W'(cand);
        grant_o[IDX_W'(cand)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master arbiter: shares one slave-side APB bus among NUM_MST masters with
// round-robin arbitration, regenerating SETUP/ACCESS on the slave side.
// Optional feature macro: APB_ARB_TIMEOUT_EN (forced completion after
// TIMEOUT_CYCLES wait states in ACCESS).
//
// state  | meaning
// IDLE   | no owner; sample M_PSEL and pick a winner
// SETUP  | slave PSEL=1, PENABLE=0 for the owner's transfer
// ACCESS | slave PSEL=1, PENABLE=1 until PREADY (or timeout)
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_MST        = NUM_MST_DEF,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                            PCLK,
  input  logic                            PRESETn,
  input  logic [NUM_MST-1:0]              M_PSEL,
  input  logic [NUM_MST-1:0]              M_PENABLE,
  input  logic [NUM_MST-1:0]              M_PWRITE,
  input  logic [NUM_MST*ADDRESS_WIDTH-1:0] M_PADDR,
  input  logic [NUM_MST*DATA_WIDTH-1:0]   M_PWDATA,
  output logic [NUM_MST-1:0]              M_PREADY,
  output logic [NUM_MST*DATA_WIDTH-1:0]   M_PRDATA,
  output logic                            S_PSEL,
  output logic                            S_PENABLE,
  output logic                            S_PWRITE,
  output logic [ADDRESS_WIDTH-1:0]        S_PADDR,
  output logic [DATA_WIDTH-1:0]           S_PWDATA,
  input  logic                            S_PREADY,
  input  logic [DATA_WIDTH-1:0]           S_PRDATA,
  output logic [NUM_MST-1:0]              GRANT,
  output logic                            BUSY,
  output logic                            PROTO_ERR,
  output logic                            TIMEOUT
);

  localparam int IDX_W = $clog2(NUM_MST);

  arb_state_t         state_q, state_d;
  logic [NUM_MST-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               proto_err_q, proto_err_d;

  logic [NUM_MST-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               owner_psel;
  logic               timeout_hit;

  logic [ADDRESS_WIDTH-1:0] paddr_a  [NUM_MST];
  logic [DATA_WIDTH-1:0]    pwdata_a [NUM_MST];
  logic [DATA_WIDTH-1:0]    prdata_a [NUM_MST];

  // PENABLE from the masters carries no information the arbiter needs.
  logic unused_penable;
  assign unused_penable = ^M_PENABLE;

  for (genvar g = 0; g < NUM_MST; g++) begin : g_slice
    assign paddr_a[g]  = M_PADDR[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign pwdata_a[g] = M_PWDATA[g*DATA_WIDTH +: DATA_WIDTH];
    assign M_PRDATA[g*DATA_WIDTH +: DATA_WIDTH] = prdata_a[g];
  end

  apb_rr_picker #(.NUM_MST(NUM_MST)) u_picker (
    .req_i   (M_PSEL),
    .last_i  (last_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign owner_psel = M_PSEL[owner_q];

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // A real PREADY in the limit cycle wins over the forced completion.
  assign timeout_hit = (state_q == ACCESS) && owner_psel && !S_PREADY &&
                       (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Count ACCESS wait states; cleared while in SETUP so each ACCESS starts at 0.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == SETUP) begin
      tmo_cnt_d = '0;
    end else if ((state_q == ACCESS) && !S_PREADY && !timeout_hit) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) tmo_cnt_q <= '0;
    else          tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
`endif

  // Next-state: arbitration in IDLE, fixed SETUP->ACCESS, completion or abort.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    last_d      = last_q;
    proto_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = SETUP;
          grant_d = pick_grant;
          owner_d = pick_idx;
          last_d  = pick_idx;
        end
      end
      SETUP: begin
        if (!owner_psel) begin
          state_d     = IDLE;
          grant_d     = '0;
          proto_err_d = 1'b1;
        end else begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!owner_psel) begin
          state_d     = IDLE;
          grant_d     = '0;
          proto_err_d = 1'b1;
        end else if (S_PREADY || timeout_hit) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // FSM and owner registers; last grant resets to the top slot so master 0 wins first.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      last_q      <= IDX_W'(NUM_MST - 1);
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Slave-side mux and owner-only response routing; everything zero in IDLE.
  always_comb begin
    S_PSEL    = (state_q != IDLE);
    S_PENABLE = (state_q == ACCESS);
    S_PWRITE  = 1'b0;
    S_PADDR   = '0;
    S_PWDATA  = '0;
    M_PREADY  = '0;
    for (int i = 0; i < NUM_MST; i++) prdata_a[i] = '0;
    if (state_q != IDLE) begin
      S_PWRITE = M_PWRITE[owner_q];
      S_PADDR  = paddr_a[owner_q];
      S_PWDATA = pwdata_a[owner_q];
    end
    if (state_q == ACCESS) begin
      M_PREADY[owner_q] = S_PREADY | timeout_hit;
      if (!timeout_hit) prdata_a[owner_q] = S_PRDATA;
    end
  end

  assign GRANT     = grant_q;
  assign BUSY      = (state_q != IDLE);
  assign PROTO_ERR = proto_err_q;
  assign TIMEOUT   = timeout_hit;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: master/slave behavioural models,
// a round-robin order predictor and a monitor that checks every completion.
module tb_apb_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TC = 8;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  logic [N-1:0]    M_PSEL, M_PENABLE, M_PWRITE;
  logic [N*AW-1:0] M_PADDR;
  logic [N*DW-1:0] M_PWDATA;
  logic [N-1:0]    M_PREADY;
  logic [N*DW-1:0] M_PRDATA;
  logic S_PSEL, S_PENABLE, S_PWRITE;
  logic [AW-1:0] S_PADDR;
  logic [DW-1:0] S_PWDATA;
  logic S_PREADY;
  logic [DW-1:0] S_PRDATA;
  logic [N-1:0] GRANT;
  logic BUSY, PROTO_ERR, TIMEOUT;

  apb_master_arbiter #(
    .NUM_MST(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TC)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .M_PSEL(M_PSEL), .M_PENABLE(M_PENABLE), .M_PWRITE(M_PWRITE),
    .M_PADDR(M_PADDR), .M_PWDATA(M_PWDATA),
    .M_PREADY(M_PREADY), .M_PRDATA(M_PRDATA),
    .S_PSEL(S_PSEL), .S_PENABLE(S_PENABLE), .S_PWRITE(S_PWRITE),
    .S_PADDR(S_PADDR), .S_PWDATA(S_PWDATA),
    .S_PREADY(S_PREADY), .S_PRDATA(S_PRDATA),
    .GRANT(GRANT), .BUSY(BUSY), .PROTO_ERR(PROTO_ERR), .TIMEOUT(TIMEOUT)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int          mst;
    logic        wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic        tmo;
  } txn_t;

  txn_t mq [N][$];
  txn_t sb [$];
  txn_t mon_e;
  logic [N-1:0] drop = '0;
  logic [N-1:0] done = '0;
  int  wait_cfg = 0;
  bit  sl_release = 1'b0;
  int  sl_cnt = 0, sl_w = 0;
  int  n_checks = 0, n_fail = 0;
  int  model_last = N - 1;
  int  cyc = 0;
  bit  gap_chk = 1'b0;
  int  last_done = -1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference order: round-robin over the per-master pending lists.
  task automatic predict();
    int rem [N];
    int pos [N];
    int total, c;
    bit got;
    total = 0;
    for (int i = 0; i < N; i++) begin
      rem[i] = mq[i].size();
      pos[i] = 0;
      total += rem[i];
    end
    while (total > 0) begin
      got = 1'b0;
      c = 0;
      for (int k = 1; k <= N; k++) begin
        if (!got && rem[(model_last + k) % N] > 0) begin
          c = (model_last + k) % N;
          got = 1'b1;
        end
      end
      sb.push_back(mq[c][pos[c]]);
      pos[c]++;
      rem[c]--;
      total--;
      model_last = c;
    end
  endtask

  task automatic add_txn(input int m, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic tmo);
    txn_t t;
    t.mst = m; t.wr = wr; t.addr = a; t.wdata = d; t.tmo = tmo;
    mq[m].push_back(t);
  endtask

  function automatic int pending();
    int p;
    p = sb.size() + (BUSY ? 1 : 0);
    for (int i = 0; i < N; i++) p += mq[i].size();
    return p;
  endfunction

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (pending() != 0 && n < 500) begin
      @(negedge PCLK);
      n++;
    end
    check(name, pending(), 0);
    repeat (2) @(negedge PCLK);
  endtask

  // Master models: hold PSEL and payload until the transfer completes.
  initial begin
    logic prev;
    M_PSEL = '0; M_PENABLE = '0; M_PWRITE = '0; M_PADDR = '0; M_PWDATA = '0;
    forever begin
      @(posedge PCLK);
      #1;
      for (int i = 0; i < N; i++) begin
        prev = M_PSEL[i];
        if (done[i]) begin
          if (mq[i].size() > 0) mq[i].delete(0);
          done[i] = 1'b0;
          prev = 1'b0;
        end
        if (mq[i].size() > 0 && !drop[i]) begin
          M_PSEL[i]   = 1'b1;
          M_PENABLE[i] = prev;
          M_PWRITE[i] = mq[i][0].wr;
          M_PADDR[i*AW +: AW]  = mq[i][0].addr;
          M_PWDATA[i*DW +: DW] = mq[i][0].wdata;
        end else begin
          M_PSEL[i] = 1'b0;
          M_PENABLE[i] = 1'b0;
          M_PWRITE[i] = 1'b0;
        end
      end
    end
  end

  // Slave model: wait states per transfer, read data = address + 0x100.
  initial begin
    S_PREADY = 1'b0;
    S_PRDATA = '0;
    forever begin
      @(posedge PCLK);
      #1;
      if (S_PSEL && !S_PENABLE) begin
        sl_cnt = 0;
        sl_w = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
        S_PREADY = 1'b0;
      end else if (S_PSEL && S_PENABLE) begin
        S_PREADY = (sl_cnt >= sl_w) || sl_release;
        sl_cnt++;
      end else begin
        S_PREADY = 1'b0;
      end
      S_PRDATA = S_PADDR + 32'h100;
    end
  end

  // Monitor: invariants every cycle, scoreboard pop on each master PREADY.
  initial begin
    forever begin
      @(negedge PCLK);
      cyc++;
      if (PRESETn) begin
        check("pready_non_owner", M_PREADY & ~GRANT, 0);
        for (int j = 0; j < N; j++)
          if (!GRANT[j]) check("prdata_non_owner", M_PRDATA[j*DW +: DW], 0);
        if (!BUSY) begin
          check("idle_ctrl", {S_PSEL, S_PENABLE, S_PWRITE, GRANT}, 0);
          check("idle_bus", {S_PADDR, S_PWDATA}, 0);
        end
        for (int i = 0; i < N; i++) begin
          if (M_PREADY[i]) begin
            done[i] = 1'b1;
            if (sb.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_pready: master %0d completed, scoreboard empty", i);
            end else begin
              mon_e = sb.pop_front();
              check("grant_order", i, mon_e.mst);
              check("s_paddr", S_PADDR, mon_e.addr);
              check("s_pwrite", S_PWRITE, mon_e.wr);
              if (mon_e.wr) check("s_pwdata", S_PWDATA, mon_e.wdata);
              else check("m_prdata", M_PRDATA[i*DW +: DW],
                         mon_e.tmo ? '0 : DW'(mon_e.addr + 32'h100));
              check("timeout_flag", TIMEOUT, mon_e.tmo);
              if (gap_chk && last_done >= 0) check("transfer_gap", cyc - last_done, 3);
              last_done = cyc;
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pen, rdy, rdy_at, busy_bad, acc;
    wait_cfg = 0;
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    check("reset_grant", GRANT, 0);
    check("reset_ctrl", {BUSY, S_PSEL, S_PENABLE, S_PWRITE, PROTO_ERR, TIMEOUT, M_PREADY}, 0);
    check("reset_data", {S_PADDR, S_PWDATA}, 0);
    check("reset_prdata", M_PRDATA, 0);
    @(negedge PCLK);

    // Single master, zero wait: cycle-accurate handshake.
    add_txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    predict();
    @(negedge PCLK);
    check("t_spsel", S_PSEL, 0);
    check("t_mpsel", M_PSEL[0], 1);
    @(negedge PCLK);
    check("t1_setup", {S_PSEL, S_PENABLE}, 2'b10);
    check("t1_grant", GRANT, 4'b0001);
    check("t1_pready", M_PREADY, 0);
    @(negedge PCLK);
    check("t2_access", {S_PSEL, S_PENABLE}, 2'b11);
    check("t2_pready", M_PREADY, 4'b0001);
    check("t2_pwdata", S_PWDATA, 32'hDEAD_BEEF);
    check("t2_paddr", S_PADDR, 32'h10);
    @(negedge PCLK);
    check("t3_grant", GRANT, 0);
    check("t3_busy", BUSY, 0);
    wait_idle("single_drain");

    // All four request at once right after reset: order 0,1,2,3.
    @(negedge PCLK);
    PRESETn = 1'b0;
    model_last = N - 1;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    wait_cfg = -1;
    for (int i = 0; i < N; i++) add_txn(i, 1'b0, AW'(i), '0, 1'b0);
    predict();
    wait_idle("all4_drain");

    // Three slave wait states on master 3.
    wait_cfg = 3;
    add_txn(3, 1'b0, 32'h3000, '0, 1'b0);
    predict();
    pen = 0; rdy = 0; rdy_at = 0; busy_bad = 0; n = 0;
    while (n < 30) begin
      @(negedge PCLK);
      n++;
      if (S_PSEL && !BUSY) busy_bad++;
      if (S_PENABLE) pen++;
      if (M_PREADY[3]) begin
        rdy++;
        rdy_at = pen;
      end
      if (pen > 0 && !BUSY) n = 30;
    end
    check("ws_penable_cycles", pen, 4);
    check("ws_pready_count", rdy, 1);
    check("ws_pready_cycle", rdy_at, 4);
    check("ws_busy", busy_bad, 0);
    wait_idle("ws_drain");

    // Masters 1 and 2 back-to-back: alternation with one IDLE gap.
    wait_cfg = 0;
    for (int k = 0; k < 3; k++) begin
      add_txn(1, 1'($urandom), $urandom, $urandom, 1'b0);
      add_txn(2, 1'($urandom), $urandom, $urandom, 1'b0);
    end
    predict();
    gap_chk = 1'b1;
    last_done = -1;
    wait_idle("b2b_drain");
    gap_chk = 1'b0;

    // Owner drops PSEL in SETUP.
    add_txn(1, 1'b1, 32'h44, 32'h1234, 1'b0);
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (!(M_PSEL[1] && !BUSY) && n < 10);
    check("abort_req_seen", M_PSEL[1] && !BUSY, 1);
    drop[1] = 1'b1;
    @(negedge PCLK);
    check("abort_setup", {S_PSEL, S_PENABLE, PROTO_ERR}, 3'b100);
    check("abort_grant", GRANT, 4'b0010);
    @(negedge PCLK);
    check("abort_idle", {BUSY, PROTO_ERR}, 2'b01);
    check("abort_grant_clr", GRANT, 0);
    @(negedge PCLK);
    check("abort_pulse_end", PROTO_ERR, 0);
    mq[1].delete();
    drop[1] = 1'b0;
    model_last = 1;
    add_txn(0, 1'b0, 32'h80, '0, 1'b0);
    add_txn(2, 1'b0, 32'h90, '0, 1'b0);
    predict();
    wait_idle("abort_drain");

    // Reset mid-ACCESS, then master 0 must win against master 3.
    wait_cfg = 20;
    add_txn(2, 1'b1, 32'hA0, 32'h5555_AAAA, 1'b0);
    predict();
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (!S_PENABLE && n < 10);
    check("rst_in_access", S_PENABLE, 1);
    PRESETn = 1'b0;
    #1;
    check("rst_mid_ctrl", {BUSY, S_PSEL, S_PENABLE, S_PWRITE, PROTO_ERR, TIMEOUT, M_PREADY, GRANT}, 0);
    check("rst_mid_data", {S_PADDR, S_PWDATA}, 0);
    check("rst_mid_prdata", M_PRDATA, 0);
    for (int i = 0; i < N; i++) mq[i].delete();
    sb.delete();
    model_last = N - 1;
    wait_cfg = -1;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    add_txn(3, 1'b0, 32'hC0, '0, 1'b0);
    add_txn(0, 1'b0, 32'hB0, '0, 1'b0);
    predict();
    wait_idle("rst_drain");

    // Randomized batches.
    for (int b = 0; b < 12; b++) begin
      for (int i = 0; i < N; i++) begin
        n = int'($urandom_range(0, 3));
        for (int k = 0; k < n; k++) add_txn(i, 1'($urandom), $urandom, $urandom, 1'b0);
      end
      predict();
      wait_idle("rand_drain");
    end

`ifdef APB_ARB_TIMEOUT_EN
    // Slave never answers: forced completion once the count reaches TC,
    // which is visible in ACCESS cycle TC+1.
    wait_cfg = 100000;
    add_txn(1, 1'b0, 32'hE0, '0, 1'b1);
    predict();
    acc = 0; n = 0; rdy_at = 0;
    while (n < 40) begin
      @(negedge PCLK);
      n++;
      if (S_PENABLE) acc++;
      if (TIMEOUT) begin
        rdy_at = acc;
        check("tmo_pready", M_PREADY, 4'b0010);
        check("tmo_prdata", M_PRDATA[1*DW +: DW], 0);
        n = 40;
      end
    end
    check("tmo_cycle", rdy_at, TC + 1);
    @(negedge PCLK);
    check("tmo_released", {S_PSEL, S_PENABLE, TIMEOUT}, 0);
    wait_cfg = -1;
    wait_idle("tmo_drain");
`else
    // Without the timeout feature ACCESS waits indefinitely.
    wait_cfg = 100000;
    add_txn(1, 1'b0, 32'hE0, '0, 1'b0);
    predict();
    repeat (100) @(negedge PCLK);
    check("notmo_waiting", {BUSY, S_PENABLE}, 2'b11);
    check("notmo_pready", M_PREADY, 0);
    check("notmo_flag", TIMEOUT, 0);
    sl_release = 1'b1;
    wait_idle("notmo_drain");
    sl_release = 1'b0;
    wait_cfg = -1;
`endif

    repeat (3) @(negedge PCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
